player_motion_ctrl: RTL
=======================

Name: player_motion_ctrl

Overview:
- Closed-loop consumer of the collision detector's `Collision_Arrow`.
- Turns button inputs and per-frame collision flags into the player sprite's position, packed as `{x[31:16], y[15:0]}`; this output feeds back as the detector's `Self_Coordinate`.
- Implements walk, jump, gravity fall, landing, head-bump and a death/respawn sequence, advancing only on the frame strobe.
- Screen y grows downward; "up" means smaller y.

Parameters:
- START_X, 16'd32: respawn x.
- START_Y, 16'd100: respawn y.
- WALK_STEP, 2: horizontal pixels moved per tick.
- JUMP_V, 6: initial upward speed in px/tick.
- MAX_FALL_V, 3: fall-speed cap; must be ≤ 3 so the detector's 3-px margin is never overshot.
- X_MIN, 16'd0: left clamp.
- X_MAX, 16'd304: right clamp, applied to the x of the top-left corner.
- Y_DEATH, 16'd240: y at or beyond which the player dies.
- RESPAWN_TICKS, 60: ticks spent in DEAD before respawn.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-clk update strobe.
- btn_left, in, 1: level input.
- btn_right, in, 1: level input.
- btn_jump, in, 1: level input.
- Collision_Arrow, in, 4: bit3 up, bit2 down, bit1 left, bit0 right.
- Self_Coordinate, out, 32: `{x, y}` of the top-left corner.
- motion_state, out, 2: 0 GROUND, 1 RISE, 2 FALL, 3 DEAD.
- on_ground, out, 1: high iff motion_state == GROUND.
- dead_pulse, out, 1: one-clk pulse on entry to DEAD.

Behaviour:
- Reset (rst high at a clk edge):
  - Self_Coordinate = {START_X, START_Y}; state = FALL; vy = 0.
  - dead_pulse = 0; respawn counter = 0; jump edge register = 0.
  - rst overrides frame_tick in the same cycle.
- All state, position and velocity updates happen only on clk edges where frame_tick = 1. Outputs hold otherwise.
- Collision_Arrow is sampled on the tick cycle. The detector lags position by 1 clk, so ticks must be ≥ 2 clk apart; ticks closer than that are out of scope.
- Jump request is the rising edge of btn_jump, detected across ticks: the btn_jump value is registered on each tick and compared with the current value. Holding the button never re-triggers a jump.
- Horizontal step, evaluated in GROUND, RISE and FALL; skipped in DEAD:
  - btn_left && !btn_right && !Arrow[1]: x = max(x − WALK_STEP, X_MIN). Do the compare first so x never wraps below 0.
  - btn_right && !btn_left && !Arrow[0]: x = min(x + WALK_STEP, X_MAX).
  - Both buttons or neither: x unchanged.
- GROUND:
  - Jump edge: go to RISE, vy = JUMP_V. y is not changed on this tick.
  - Else if !Arrow[2] (walked off a ledge): go to FALL, vy = 0.
  - Else stay; y unchanged.
  - Jump takes priority over walking off a ledge in the same tick.
- RISE:
  - Arrow[3] (head bump): go to FALL, vy = 0; y unchanged this tick.
  - Else y = y − vy, then vy = vy − 1. When vy reaches 0, go to FALL.
  - If y − vy would underflow below 0, set y = 0 and go to FALL.
- FALL:
  - Arrow[2]: go to GROUND, vy = 0; y unchanged. Landing is checked before gravity.
  - Else y = y + vy, then vy = min(vy + 1, MAX_FALL_V).
  - If the new y ≥ Y_DEATH: go to DEAD, counter = 0, dead_pulse = 1 for exactly one clk.
- DEAD:
  - Position frozen; buttons and collisions ignored.
  - Counter increments per tick. On the tick where the counter would reach RESPAWN_TICKS: Self_Coordinate = {START_X, START_Y}, state = FALL, vy = 0, counter = 0.
- Simultaneous collision flags:
  - Arrow[2] and Arrow[3] both set in FALL: land.
  - Both set in RISE: bump to FALL; landing is then resolved on the next tick.
  - Arrow[1] and Arrow[0] each gate only their own direction.
- Arithmetic: 16-bit unsigned coordinates; vy is a 4-bit unsigned magnitude; direction is implied by the state.

Optional Feature:
- Macro DOUBLE_JUMP_EN.
- Defined:
  - A one-bit air_jump_avail is set on entry to GROUND and on reset.
  - A jump edge in RISE or FALL while air_jump_avail = 1 sets state = RISE, vy = JUMP_V, air_jump_avail = 0.
  - A head bump in the same tick wins over the air jump.
- Undefined: jump edges outside GROUND are ignored and no extra register is built.

Test Plan:
- Reset then ticks with Arrow = 4'b0000 → after tick 1 y = 100 (vy was 0); after tick 4 y = 100+1+2+3 = 106; vy capped at 3 thereafter.
- In FALL, Arrow = 4'b0100 on a tick → state GROUND, on_ground = 1, y unchanged; next tick with jump edge → RISE, vy = 6; following ticks y decreases by 6, 5, 4, 3, 2, 1 (total 21), then FALL.
- In RISE with vy = 4, Arrow[3] = 1 → FALL, vy = 0, y unchanged; next tick y + 0, vy = 1.
- GROUND at x = 1, btn_left held → x = 0 and stays 0; btn_right with Arrow[0] = 1 → x unchanged; both buttons → x unchanged.
- FALL from y = 238 with vy = 3, no collision → y = 241 ≥ 240, DEAD, dead_pulse high for 1 clk; after 60 ticks Coordinate = {32, 100}, state FALL; assert rst mid-DEAD → immediate respawn values, counter 0.
- DOUBLE_JUMP_EN defined: jump in GROUND, second edge during RISE → vy reloaded to 6; third edge ignored. Undefined: second edge ignored.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - frame-tick player walk/jump/gravity/death FSM fed by collision arrows.
// Optional DOUBLE_JUMP_EN adds one mid-air jump per ground contact.
module player_motion_ctrl #(
   parameter logic [15:0] START_X       = 16'd32,
   parameter logic [15:0] START_Y       = 16'd100,
   parameter int          WALK_STEP     = 2,
   parameter int          JUMP_V        = 6,
   parameter int          MAX_FALL_V    = 3,
   parameter logic [15:0] X_MIN         = 16'd0,
   parameter logic [15:0] X_MAX         = 16'd304,
   parameter logic [15:0] Y_DEATH       = 16'd240,
   parameter int          RESPAWN_TICKS = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic [3:0]  Collision_Arrow,
   output logic [31:0] Self_Coordinate,
   output logic [1:0]  motion_state,
   output logic        on_ground,
   output logic        dead_pulse
);

   localparam int CNT_W = $clog2(RESPAWN_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_TICKS - 1);
   localparam logic [15:0] STEP16  = 16'(WALK_STEP);
   localparam logic [3:0]  JUMP_V4 = 4'(JUMP_V);
   localparam logic [3:0]  MAXV4   = 4'(MAX_FALL_V);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2,
      ST_DEAD   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      x_q, x_d, y_q, y_d;
   logic [3:0]       vy_q, vy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             jump_prev_q, jump_prev_d;
   logic             dead_pulse_q, dead_pulse_d;
   logic             jump_edge, air_jump_ok;
   logic [16:0]      right_sum, fall_sum;

`ifdef DOUBLE_JUMP_EN
   logic             air_q, air_d;
`endif

   assign jump_edge = btn_jump && !jump_prev_q;
   assign right_sum = {1'b0, x_q} + {1'b0, STEP16};
   assign fall_sum  = {1'b0, y_q} + {13'd0, vy_q};

`ifdef DOUBLE_JUMP_EN
   assign air_jump_ok = jump_edge && air_q;
`else
   assign air_jump_ok = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      vy_d         = vy_q;
      cnt_d        = cnt_q;
      jump_prev_d  = jump_prev_q;
      dead_pulse_d = 1'b0;
`ifdef DOUBLE_JUMP_EN
      air_d        = air_q;
`endif
      if (frame_tick) begin
         jump_prev_d = btn_jump;
         // Left compare is done before subtracting so x never wraps below X_MIN.
         if (state_q != ST_DEAD) begin
            if (btn_left && !btn_right && !Collision_Arrow[1]) begin
               x_d = (x_q >= X_MIN + STEP16) ? x_q - STEP16 : X_MIN;
            end else if (btn_right && !btn_left && !Collision_Arrow[0]) begin
               x_d = (right_sum > {1'b0, X_MAX}) ? X_MAX : right_sum[15:0];
            end
         end
         case (state_q)
            ST_GROUND: begin
               if (jump_edge) begin
                  state_d = ST_RISE;
                  vy_d    = JUMP_V4;
               end else if (!Collision_Arrow[2]) begin
                  state_d = ST_FALL;
                  vy_d    = 4'd0;
               end
            end
            ST_RISE: begin
               if (Collision_Arrow[3]) begin
                  state_d = ST_FALL;
                  vy_d    = 4'd0;
               end else if (air_jump_ok) begin
                  vy_d = JUMP_V4;
`ifdef DOUBLE_JUMP_EN
                  air_d = 1'b0;
`endif
               end else if ({12'd0, vy_q} > y_q) begin
                  y_d     = 16'd0;
                  state_d = ST_FALL;
                  vy_d    = 4'd0;
               end else begin
                  y_d = y_q - {12'd0, vy_q};
                  if (vy_q <= 4'd1) begin
                     state_d = ST_FALL;
                     vy_d    = 4'd0;
                  end else begin
                     vy_d = vy_q - 4'd1;
                  end
               end
            end
            ST_FALL: begin
               if (Collision_Arrow[2]) begin
                  state_d = ST_GROUND;
                  vy_d    = 4'd0;
`ifdef DOUBLE_JUMP_EN
                  air_d   = 1'b1;
`endif
               end else if (air_jump_ok) begin
                  state_d = ST_RISE;
                  vy_d    = JUMP_V4;
`ifdef DOUBLE_JUMP_EN
                  air_d   = 1'b0;
`endif
               end else begin
                  y_d  = fall_sum[15:0];
                  vy_d = (vy_q >= MAXV4) ? MAXV4 : vy_q + 4'd1;
                  if (fall_sum >= {1'b0, Y_DEATH}) begin
                     state_d      = ST_DEAD;
                     cnt_d        = '0;
                     dead_pulse_d = 1'b1;
                  end
               end
            end
            default: begin
               if (cnt_q == CNT_LAST) begin
                  x_d     = START_X;
                  y_d     = START_Y;
                  state_d = ST_FALL;
                  vy_d    = 4'd0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FALL;
         x_q          <= START_X;
         y_q          <= START_Y;
         vy_q         <= 4'd0;
         cnt_q        <= '0;
         jump_prev_q  <= 1'b0;
         dead_pulse_q <= 1'b0;
`ifdef DOUBLE_JUMP_EN
         air_q        <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         vy_q         <= vy_d;
         cnt_q        <= cnt_d;
         jump_prev_q  <= jump_prev_d;
         dead_pulse_q <= dead_pulse_d;
`ifdef DOUBLE_JUMP_EN
         air_q        <= air_d;
`endif
      end
   end

   assign Self_Coordinate = {x_q, y_q};
   assign motion_state    = state_q;
   assign on_ground       = (state_q == ST_GROUND);
   assign dead_pulse      = dead_pulse_q;

endmodule
